// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter
//
// Owns the RW port 0 of the dual-port SRAM macro. It shares that port between
// two requesters with round-robin arbitration, and accepts one access per cycle.
// It tracks the 2-edge read latency, so each read response returns to the
// requester that issued it. A built-in init engine zero-fills the whole array
// and has priority over both requesters.
//
// Port summary
//   wb_clk_i, wb_rst_i      block clock (also the macro clk0); async active-high reset
//   reqN_valid/we/wmask/addr/wdata   request from requester N (0 = bus bridge, 1 = DMA)
//   reqN_ready               combinational grant; accept on valid & ready at the clock edge
//   reqN_rvalid/rdata        one-cycle read response
//   init_start               pulse that starts a zero-fill
//   init_busy/init_done      fill in progress / one-cycle completion pulse
//   sram_csb0..sram_din0     registered macro port 0 controls (active-low csb/web)
//   sram_dout0               macro read data
//
// Handshake: a requester raises valid and holds valid and every payload field
// stable. The transfer takes place on the rising edge where valid and ready are
// both 1. ready never depends on anything that is registered on that same edge.
// rvalid is a single-cycle strobe that does not wait for a ready; the requester
// must take the data in that cycle.
module sram_port0_arbiter #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_WMASKS    = 4,
    parameter int INIT_ON_RESET = 0
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [NUM_WMASKS-1:0] req0_wmask,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_rvalid,
    output logic [DATA_WIDTH-1:0] req0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [NUM_WMASKS-1:0] req1_wmask,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_rvalid,
    output logic [DATA_WIDTH-1:0] req1_rdata,

    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,

    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } init_state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    // Init engine state
    init_state_t           state_q;
    logic [ADDR_WIDTH-1:0] fill_cnt_q;
    logic                  auto_start_q;   // one-shot start request after reset

    // Arbitration: 1 = req1 won the most recent grant, so req0 is favoured next
    logic                  last_grant_q;

    // Macro port registers
    logic                  csb_q,   csb_d;
    logic                  web_q,   web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] din_q,   din_d;

    // Read tag pipeline: stage 1 = edge k, stage 2 = edge k+1, data captured at k+2
    logic                  tag1_v_q, tag1_id_q;
    logic                  tag2_v_q, tag2_id_q;
    logic                  rd_issue_d;
    logic                  rvalid_q, rid_q;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

    logic init_take;
    logic arb_block;
    logic grant0, grant1;

    // The init engine wins in the cycle it starts as well, so that a requester
    // is never accepted on the same edge the fill begins.
    assign init_take = (state_q == ST_IDLE) && (init_start || auto_start_q);
    assign arb_block = (state_q == ST_FILL) || init_take;

    assign grant0 = !arb_block && req0_valid && (!req1_valid || last_grant_q);
    assign grant1 = !arb_block && req1_valid && (!req0_valid || !last_grant_q);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        csb_d      = 1'b1;
        web_d      = 1'b1;
        wmask_d    = wmask_q;
        addr_d     = addr_q;
        din_d      = din_q;
        rd_issue_d = 1'b0;
        if (state_q == ST_FILL) begin
            csb_d   = 1'b0;
            web_d   = 1'b0;
            wmask_d = '1;
            addr_d  = fill_cnt_q;
            din_d   = '0;
        end else if (grant0) begin
            csb_d      = 1'b0;
            web_d      = !req0_we;
            wmask_d    = req0_wmask;
            addr_d     = req0_addr;
            din_d      = req0_wdata;
            rd_issue_d = !req0_we;
        end else if (grant1) begin
            csb_d      = 1'b0;
            web_d      = !req1_we;
            wmask_d    = req1_wmask;
            addr_d     = req1_addr;
            din_d      = req1_wdata;
            rd_issue_d = !req1_we;
        end
    end

    // Init engine FSM
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            fill_cnt_q   <= '0;
            auto_start_q <= (INIT_ON_RESET != 0);
        end else begin
            auto_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_take) begin
                        state_q    <= ST_FILL;
                        fill_cnt_q <= '0;
                    end
                end
                ST_FILL: begin
                    // Stop on the last address rather than letting the counter wrap.
                    if (fill_cnt_q == LAST_ADDR) begin
                        state_q <= ST_DONE;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + ADDR_ONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign init_busy = (state_q == ST_FILL);
    assign init_done = (state_q == ST_DONE);

    // Macro port, arbitration pointer and response pipeline
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            csb_q        <= 1'b1;
            web_q        <= 1'b1;
            wmask_q      <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            last_grant_q <= 1'b1;
            tag1_v_q     <= 1'b0;
            tag1_id_q    <= 1'b0;
            tag2_v_q     <= 1'b0;
            tag2_id_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rid_q        <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;

            if (grant0) begin
                last_grant_q <= 1'b0;
            end else if (grant1) begin
                last_grant_q <= 1'b1;
            end

            tag1_v_q  <= rd_issue_d;
            tag1_id_q <= grant1;
            tag2_v_q  <= tag1_v_q;
            tag2_id_q <= tag1_id_q;

            rvalid_q <= tag2_v_q;
            rid_q    <= tag2_id_q;
            if (tag2_v_q && !tag2_id_q) begin
                rdata0_q <= sram_dout0;
            end
            if (tag2_v_q && tag2_id_q) begin
                rdata1_q <= sram_dout0;
            end
        end
    end

    assign req0_rvalid = rvalid_q && !rid_q;
    assign req1_rvalid = rvalid_q && rid_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
module tb_sram_port0_arbiter;

    localparam int AW = 9;
    localparam int DW = 32;
    localparam int MW = 4;

    // ---------------------------------------------------------------- clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- DUT signals
    logic          req0_valid = 0, req0_we = 0;
    logic [MW-1:0] req0_wmask = '0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready, req0_rvalid;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 0, req1_we = 0;
    logic [MW-1:0] req1_wmask = '0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready, req1_rvalid;
    logic [DW-1:0] req1_rdata;
    logic          init_start = 0, init_busy, init_done;
    logic          sram_csb0, sram_web0;
    logic [MW-1:0] sram_wmask0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic [DW-1:0] sram_dout0 = '0;

    sram_port0_arbiter u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_wmask(req0_wmask),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_wmask(req1_wmask),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // Second instance: fill starts by itself after reset
    logic          a_req0_ready, a_req0_rvalid, a_req1_ready, a_req1_rvalid;
    logic [DW-1:0] a_req0_rdata, a_req1_rdata;
    logic          a_busy, a_done, a_csb, a_web;
    logic [MW-1:0] a_wmask;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;

    sram_port0_arbiter #(.INIT_ON_RESET(1)) u_auto (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req0_valid(1'b1), .req0_we(1'b0), .req0_wmask(4'h0),
        .req0_addr(9'h000), .req0_wdata(32'h0), .req0_ready(a_req0_ready),
        .req0_rvalid(a_req0_rvalid), .req0_rdata(a_req0_rdata),
        .req1_valid(1'b0), .req1_we(1'b0), .req1_wmask(4'h0),
        .req1_addr(9'h000), .req1_wdata(32'h0), .req1_ready(a_req1_ready),
        .req1_rvalid(a_req1_rvalid), .req1_rdata(a_req1_rdata),
        .init_start(1'b0), .init_busy(a_busy), .init_done(a_done),
        .sram_csb0(a_csb), .sram_web0(a_web), .sram_wmask0(a_wmask),
        .sram_addr0(a_addr), .sram_din0(a_din), .sram_dout0(32'h0)
    );

    // ---------------------------------------------------------------- SRAM macro model
    // Inputs sampled on the rising edge, array access on the following falling edge.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          csb_l = 1'b1, web_l = 1'b1;
    logic [MW-1:0] wm_l = '0;
    logic [AW-1:0] ad_l = '0;
    logic [DW-1:0] din_l = '0;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA500_0000 | i;
    end

    always @(posedge clk) begin
        csb_l <= sram_csb0;
        web_l <= sram_web0;
        wm_l  <= sram_wmask0;
        ad_l  <= sram_addr0;
        din_l <= sram_din0;
    end

    always @(negedge clk) begin
        if (!csb_l) begin
            if (!web_l) begin
                for (int b = 0; b < MW; b++)
                    if (wm_l[b]) mem[ad_l][8*b +: 8] <= din_l[8*b +: 8];
            end else begin
                sram_dout0 <= mem[ad_l];
            end
        end
    end

    // ---------------------------------------------------------------- scoreboard
    int n_checks = 0;
    int n_errors = 0;
    logic [DW:0] exp_q[$];   // {requester id, data}

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
        logic ok;
        ok = 1'b0;
        if (n == 0) begin
            req0_valid = 1; req0_we = we; req0_addr = a; req0_wdata = d; req0_wmask = m;
        end else begin
            req1_valid = 1; req1_we = we; req1_addr = a; req1_wdata = d; req1_wmask = m;
        end
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk);
            ok = (n == 0) ? req0_ready : req1_ready;
            @(posedge clk); #1;
        end
        if (n == 0) req0_valid = 0; else req1_valid = 0;
        check_eq("accept", ok, 1);
    endtask

    // Response must appear exactly in the cycle after the second edge past the accept.
    task automatic expect_read(input int n, input logic [DW-1:0] exp, input string tag);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq({tag, "_rv0"}, req0_rvalid, (j == 2) && (n == 0));
            check_eq({tag, "_rv1"}, req1_rvalid, (j == 2) && (n == 1));
        end
        check_eq({tag, "_data"}, (n == 0) ? req0_rdata : req1_rdata, exp);
        @(posedge clk); #1;
    endtask

    // Checks the first cycles after a reset release (also the auto-fill start).
    task automatic post_reset_checks(input string tag);
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check_eq({tag, "_rv"}, {req1_rvalid, req0_rvalid}, 2'b00);
            check_eq({tag, "_csb"}, sram_csb0, 1);
            if (j == 0) begin
                check_eq({tag, "_web"}, sram_web0, 1);
                check_eq({tag, "_busy"}, init_busy, 0);
                check_eq({tag, "_auto_rdy"}, a_req0_ready, 0);
                check_eq({tag, "_auto_idle"}, a_busy, 0);
            end
            if (j == 1) check_eq({tag, "_auto_fill"}, a_busy, 1);
            @(posedge clk); #1;
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    int busy_cnt, wr_cnt, done_cnt, rdy_busy;
    logic got;
    logic [DW:0] e;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_csb", sram_csb0, 1);
        check_eq("rst_web", sram_web0, 1);
        check_eq("rst_addr", sram_addr0, 0);
        check_eq("rst_din", sram_din0, 0);
        check_eq("rst_wmask", sram_wmask0, 0);
        check_eq("rst_rdata", {req1_rdata, req0_rdata}, 0);
        check_eq("rst_done", init_done, 0);
        @(posedge clk); #1;
        rst = 0;
        post_reset_checks("start");

        // Basic write then read
        issue(0, 1, 9'h005, 32'hDEADBEEF, 4'hF);
        issue(0, 0, 9'h005, 32'h0, 4'h0);
        expect_read(0, 32'hDEADBEEF, "wr_rd");

        // Byte mask: only lane 1 updated
        issue(0, 1, 9'h010, 32'h11223344, 4'hF);
        issue(0, 1, 9'h010, 32'hAABBCCDD, 4'h2);
        issue(0, 0, 9'h010, 32'h0, 4'h0);
        expect_read(0, 32'h1122CC44, "mask");

        // Write by req1, read by req0 on the very next edge
        issue(1, 1, 9'h030, 32'h0BADF00D, 4'hF);
        issue(0, 0, 9'h030, 32'h0, 4'h0);
        expect_read(0, 32'h0BADF00D, "raw");

        // Round robin: last grant goes to req1, so req0 wins first
        issue(0, 1, 9'h020, 32'hC0DE0020, 4'hF);
        issue(1, 1, 9'h021, 32'hC0DE0021, 4'hF);
        req0_valid = 1; req0_we = 0; req0_addr = 9'h020;
        req1_valid = 1; req1_we = 0; req1_addr = 9'h021;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (j < 8) begin
                check_eq("rr_rdy0", req0_ready, (j % 2) == 0);
                check_eq("rr_rdy1", req1_ready, (j % 2) == 1);
                exp_q.push_back((j % 2) == 0 ? {1'b0, 32'hC0DE0020} : {1'b1, 32'hC0DE0021});
            end
            if (j >= 3 && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_eq("rr_rv", {req1_rvalid, req0_rvalid}, e[DW] ? 2'b10 : 2'b01);
                check_eq("rr_data", e[DW] ? req1_rdata : req0_rdata, e[DW-1:0]);
            end else begin
                check_eq("rr_idle_rv", {req1_rvalid, req0_rvalid}, 2'b00);
            end
            @(posedge clk); #1;
            if (j == 7) begin
                req0_valid = 0;
                req1_valid = 0;
            end
        end
        check_eq("rr_drained", exp_q.size(), 0);

        // Zero-fill with req0 waiting
        issue(1, 1, 9'h1FF, 32'h12345678, 4'hF);
        issue(0, 0, 9'h1FF, 32'h0, 4'h0);
        expect_read(0, 32'h12345678, "preload");
        req0_valid = 1; req0_we = 0; req0_addr = 9'h000;
        init_start = 1;
        busy_cnt = 0; wr_cnt = 0; done_cnt = 0; rdy_busy = 0; got = 0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge clk);
            if (c == 0) check_eq("init_wins", req0_ready, 0);
            if (init_busy) busy_cnt++;
            if (init_busy && req0_ready) rdy_busy++;
            if (!sram_csb0 && !sram_web0) wr_cnt++;
            if (init_done) begin
                done_cnt++;
                check_eq("fill_last_addr", sram_addr0, 9'h1FF);
                check_eq("fill_last_din", sram_din0, 0);
                check_eq("fill_last_mask", sram_wmask0, 4'hF);
            end
            if (req0_ready) got = 1;
            @(posedge clk); #1;
            init_start = (c == 99);   // pulse while busy must be ignored
        end
        req0_valid = 0;
        check_eq("init_granted", got, 1);
        check_eq("init_busy_cycles", busy_cnt, 512);
        check_eq("init_writes", wr_cnt, 512);
        check_eq("init_done_pulses", done_cnt, 1);
        check_eq("init_ready_while_busy", rdy_busy, 0);
        expect_read(0, 32'h0, "fill_0x000");
        check_eq("init_no_restart", init_busy, 0);
        issue(0, 0, 9'h1FF, 32'h0, 4'h0);
        expect_read(0, 32'h0, "fill_0x1ff");
        issue(1, 0, 9'h100, 32'h0, 4'h0);
        expect_read(1, 32'h0, "fill_0x100");

        // Reset one cycle after a read accept
        issue(0, 0, 9'h010, 32'h0, 4'h0);
        @(posedge clk); #1;
        rst = 1;
        #1;
        check_eq("midrst_csb", sram_csb0, 1);
        @(negedge clk);
        check_eq("midrst_rv", {req1_rvalid, req0_rvalid}, 2'b00);
        check_eq("midrst_auto_busy", a_busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 0;
        post_reset_checks("midrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
